// File: rtl/bank_pkg.sv
// Shared types, default geometry/timing and burst addressing for the DRAM bank model.
package bank_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_WRITING,
    ST_READING,
    ST_PRECHARGING
  } state_e;

  localparam int DEF_DEVICE_WIDTH = 4;
  localparam int DEF_COLWIDTH     = 10;
  localparam int DEF_CHWIDTH      = 5;
  localparam int DEF_BL           = 8;
  localparam int DEF_TRCD         = 3;
  localparam int DEF_TRP          = 3;
  localparam int DEF_TCL          = 2;

  localparam int BURSTW = $clog2(DEF_BL);

  // Column of beat k: upper bits fixed, low bw bits wrap inside the BL-aligned block.
  function automatic logic [31:0] burst_col(input logic [31:0] column,
                                            input logic [31:0] k,
                                            input int          bw);
    logic [31:0] mask;
    mask = (32'd1 << bw) - 32'd1;
    return (column & ~mask) | ((column + k) & mask);
  endfunction

endpackage

// File: rtl/bank_array.sv
// Single-port storage for one bank: synchronous write, one-cycle registered read.
module bank_array
  import bank_pkg::*;
#(
  parameter int DEVICE_WIDTH = DEF_DEVICE_WIDTH,
  parameter int AW           = DEF_CHWIDTH + DEF_COLWIDTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [AW-1:0]           addr,
  input  logic [DEVICE_WIDTH-1:0] wdata,
  output logic [DEVICE_WIDTH-1:0] rdata
);

  logic [DEVICE_WIDTH-1:0] mem [2**AW];

  // NOTE: storage has no reset so it maps onto RAM macros; non-blocking keeps
  // read-during-write ordering independent of process scheduling.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bank_fsm.sv
// One DRAM bank: row-buffer state machine with tRCD/tRP/tCL timing and wrapped bursts.
module bank_fsm
  import bank_pkg::*;
#(
  parameter int DEVICE_WIDTH = DEF_DEVICE_WIDTH,
  parameter int COLWIDTH     = DEF_COLWIDTH,
  parameter int CHWIDTH      = DEF_CHWIDTH,
  parameter int BL           = DEF_BL,
  parameter int TRCD         = DEF_TRCD,
  parameter int TRP          = DEF_TRP,
  parameter int TCL          = DEF_TCL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  cmd_e                    cmd,
  input  logic [CHWIDTH-1:0]      row,
  input  logic [COLWIDTH-1:0]     column,
  input  logic [DEVICE_WIDTH-1:0] dqin,
  output logic [DEVICE_WIDTH-1:0] dqout,
  output logic                    dqout_valid,
  output logic                    row_open,
  output logic [CHWIDTH-1:0]      open_row,
  output logic                    cmd_err
);

  localparam int BEAT_W = $clog2(BL);
  localparam int TMAX   = (TRCD > TRP) ? ((TRCD > TCL) ? TRCD : TCL)
                                       : ((TRP > TCL) ? TRP : TCL);
  localparam int TW     = $clog2(TMAX + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BL - 1);

  state_e              state, state_n;
  logic [CHWIDTH-1:0]  open_row_n;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [BEAT_W-1:0]   beat, beat_n;
  logic [COLWIDTH-1:0] col_base, col_base_n;
  logic                rd_issue, rd_issue_n;
  logic                cmd_err_n;
  logic                accept;

  logic [COLWIDTH-1:0]     col_k;
  logic                    arr_we, arr_re;
  logic [DEVICE_WIDTH-1:0] arr_rdata;

  logic [TCL-1:0]          vld_pipe;
  logic [DEVICE_WIDTH-1:0] dat_pipe [TCL-1];

  assign cmd_ready = !rst && (state == ST_IDLE || state == ST_ACTIVE);
  assign accept    = cmd_valid && cmd_ready;
  assign row_open  = (state == ST_ACTIVE) || (state == ST_WRITING) || (state == ST_READING);

  assign col_k  = COLWIDTH'(burst_col(32'(col_base), 32'(beat), BEAT_W));
  assign arr_we = !rst && (state == ST_WRITING);
  assign arr_re = !rst && (state == ST_READING) && rd_issue;

  // NOTE: every variable gets its hold value before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    open_row_n = open_row;
    tcnt_n     = tcnt;
    beat_n     = beat;
    col_base_n = col_base;
    rd_issue_n = rd_issue;
    cmd_err_n  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd)
            CMD_ACT: begin
              open_row_n = row;
              tcnt_n     = TW'(TRCD - 1);
              state_n    = ST_ACTIVATING;
            end
            CMD_RD, CMD_WR: cmd_err_n = 1'b1;
            default: ;
          endcase
        end
      end

      ST_ACTIVATING: begin
        if (tcnt == '0) state_n = ST_ACTIVE;
        else            tcnt_n  = tcnt - 1'b1;
      end

      ST_ACTIVE: begin
        if (accept) begin
          unique case (cmd)
            CMD_PRE: begin
              tcnt_n  = TW'(TRP - 1);
              state_n = ST_PRECHARGING;
            end
            CMD_WR: begin
              beat_n     = '0;
              col_base_n = column;
              state_n    = ST_WRITING;
            end
            CMD_RD: begin
              beat_n     = '0;
              col_base_n = column;
              rd_issue_n = 1'b1;
              state_n    = ST_READING;
            end
            CMD_ACT: cmd_err_n = 1'b1;
            default: ;
          endcase
        end
      end

      ST_WRITING: begin
        beat_n = beat + 1'b1;
        if (beat == LAST_BEAT) state_n = ST_ACTIVE;
      end

      // Issue BL array reads, then hold until the last beat leaves the tCL pipe.
      ST_READING: begin
        if (rd_issue) begin
          beat_n = beat + 1'b1;
          if (beat == LAST_BEAT) begin
            rd_issue_n = 1'b0;
            tcnt_n     = TW'(TCL - 2);
          end
        end else if (tcnt == '0) begin
          state_n = ST_ACTIVE;
        end else begin
          tcnt_n = tcnt - 1'b1;
        end
      end

      ST_PRECHARGING: begin
        if (tcnt == '0) state_n = ST_IDLE;
        else            tcnt_n  = tcnt - 1'b1;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      open_row <= '0;
      tcnt     <= '0;
      beat     <= '0;
      col_base <= '0;
      rd_issue <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= state_n;
      open_row <= open_row_n;
      tcnt     <= tcnt_n;
      beat     <= beat_n;
      col_base <= col_base_n;
      rd_issue <= rd_issue_n;
      cmd_err  <= cmd_err_n;
    end
  end

  bank_array #(
    .DEVICE_WIDTH(DEVICE_WIDTH),
    .AW          (CHWIDTH + COLWIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .addr ({open_row, col_k}),
    .wdata(dqin),
    .rdata(arr_rdata)
  );

  // Array supplies one cycle of read latency; TCL-1 further stages make up tCL.
  // Data stages only load behind a valid beat so dqout holds the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < TCL - 1; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[TCL-2:0], arr_re};
      if (vld_pipe[0]) dat_pipe[0] <= arr_rdata;
      for (int i = 1; i < TCL - 1; i++) begin
        if (vld_pipe[i]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign dqout       = dat_pipe[TCL-2];
  assign dqout_valid = vld_pipe[TCL-1];

endmodule

// File: tb/tb_bank_fsm.sv
// Bench for bank_fsm: expected read beats queued at RD issue, compared as dqout_valid beats appear.
module tb_bank_fsm;
  import bank_pkg::*;

  localparam int BL   = 8;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TCL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  cmd_e       cmd = CMD_NOP;
  logic [4:0] row = '0;
  logic [9:0] column = '0;
  logic [3:0] dqin = '0;
  logic [3:0] dqout;
  logic       dqout_valid;
  logic       row_open;
  logic [4:0] open_row;
  logic       cmd_err;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q [$];
  logic [3:0] model [logic [14:0]];
  logic [4:0] cur_row = '0;

  always #5 clk = ~clk;

  bank_fsm #(
    .DEVICE_WIDTH(4), .COLWIDTH(10), .CHWIDTH(5),
    .BL(BL), .TRCD(TRCD), .TRP(TRP), .TCL(TCL)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .row(row), .column(column), .dqin(dqin),
    .dqout(dqout), .dqout_valid(dqout_valid),
    .row_open(row_open), .open_row(open_row), .cmd_err(cmd_err)
  );

  // Scoreboard consumer: every read beat must match the oldest expectation.
  always @(negedge clk) begin
    if (dqout_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read_beat: unexpected beat %0h, none required", dqout);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (dqout !== e) begin
          fails++;
          $display("FAIL read_beat: got %0h required %0h", dqout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] bcol(input logic [9:0] c, input int k);
    logic [2:0] lo;
    lo = 3'(c[2:0] + k);
    return {c[9:3], lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
  endtask

  // Returns just after the accepting edge E0.
  task automatic issue(input cmd_e c, input logic [4:0] r, input logic [9:0] col);
    wait_ready();
    cmd_valid = 1'b1;
    cmd = c;
    row = r;
    column = col;
    tick();
    cmd_valid = 1'b0;
    cmd = CMD_NOP;
  endtask

  task automatic activate(input logic [4:0] r);
    issue(CMD_ACT, r, '0);
    cur_row = r;
    repeat (TRCD) tick();
  endtask

  task automatic precharge();
    issue(CMD_PRE, '0, '0);
    repeat (TRP) tick();
  endtask

  // A beat at stop_at asserts rst on its edge instead of being written.
  task automatic write_burst(input logic [9:0] col, input logic [3:0] d [BL], input int stop_at);
    issue(CMD_WR, '0, col);
    for (int k = 0; k < BL; k++) begin
      dqin = d[k];
      if (k == stop_at) begin
        rst = 1'b1;
        tick();
        return;
      end
      model[{cur_row, bcol(col, k)}] = d[k];
      tick();
    end
  endtask

  task automatic read_burst(input logic [9:0] col, input bit from_model);
    if (from_model)
      for (int k = 0; k < BL; k++) exp_q.push_back(model[{cur_row, bcol(col, k)}]);
    issue(CMD_RD, '0, col);
    for (int j = 0; j <= TCL + BL; j++) begin
      tests += 2;
      if (dqout_valid !== (j >= TCL && j < TCL + BL)) begin
        fails++;
        $display("FAIL rd_valid_timing: edge E0+%0d dqout_valid=%b required %b",
                 j, dqout_valid, (j >= TCL && j < TCL + BL));
      end
      if (cmd_ready !== (j >= TCL + BL - 1)) begin
        fails++;
        $display("FAIL rd_ready_timing: edge E0+%0d cmd_ready=%b required %b",
                 j, cmd_ready, (j >= TCL + BL - 1));
      end
      tick();
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rd_drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests += 5;
    if (cmd_ready !== 1'b0)   begin fails++; $display("FAIL reset_ready: got %b required 0", cmd_ready); end
    if (dqout_valid !== 1'b0) begin fails++; $display("FAIL reset_dqout_valid: got %b required 0", dqout_valid); end
    if (row_open !== 1'b0)    begin fails++; $display("FAIL reset_row_open: got %b required 0", row_open); end
    if (open_row !== 5'd0)    begin fails++; $display("FAIL reset_open_row: got %0d required 0", open_row); end
    if (cmd_err !== 1'b0)     begin fails++; $display("FAIL reset_cmd_err: got %b required 0", cmd_err); end
    rst = 1'b0;
    #1;
    tests += 2;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b required 1", cmd_ready); end
    if (dqout !== 4'd0)     begin fails++; $display("FAIL reset_dqout: got %0h required 0", dqout); end
  endtask

  task automatic test_illegal_idle();
    issue(CMD_RD, '0, 10'd0);
    tests += 2;
    if (cmd_err !== 1'b1)   begin fails++; $display("FAIL rd_idle_err: got %b required 1", cmd_err); end
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rd_idle_ready: got %b required 1", cmd_ready); end
    for (int j = 0; j < 4; j++) begin
      tick();
      tests += 2;
      if (cmd_err !== 1'b0)     begin fails++; $display("FAIL rd_idle_err_pulse: cycle %0d got %b required 0", j, cmd_err); end
      if (dqout_valid !== 1'b0) begin fails++; $display("FAIL rd_idle_no_data: cycle %0d got %b required 0", j, dqout_valid); end
    end
    issue(CMD_PRE, '0, '0);
    tests += 3;
    if (cmd_err !== 1'b0)   begin fails++; $display("FAIL pre_idle_err: got %b required 0", cmd_err); end
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL pre_idle_ready: got %b required 1", cmd_ready); end
    if (row_open !== 1'b0)  begin fails++; $display("FAIL pre_idle_row_open: got %b required 0", row_open); end
  endtask

  task automatic test_activate();
    issue(CMD_ACT, 5'd1, '0);
    cur_row = 5'd1;
    for (int j = 0; j <= TRCD; j++) begin
      tests += 2;
      if (cmd_ready !== (j == TRCD)) begin fails++; $display("FAIL act_ready: E0+%0d got %b required %b", j, cmd_ready, (j == TRCD)); end
      if (row_open !== (j == TRCD))  begin fails++; $display("FAIL act_row_open: E0+%0d got %b required %b", j, row_open, (j == TRCD)); end
      if (j < TRCD) tick();
    end
    tests++;
    if (open_row !== 5'd1) begin fails++; $display("FAIL act_open_row: got %0d required 1", open_row); end
  endtask

  task automatic test_illegal_active();
    issue(CMD_ACT, 5'd7, '0);
    tests += 3;
    if (cmd_err !== 1'b1)  begin fails++; $display("FAIL act_active_err: got %b required 1", cmd_err); end
    if (open_row !== 5'd1) begin fails++; $display("FAIL act_active_open_row: got %0d required 1", open_row); end
    if (row_open !== 1'b1) begin fails++; $display("FAIL act_active_row_open: got %b required 1", row_open); end
    tick();
    tests++;
    if (cmd_err !== 1'b0) begin fails++; $display("FAIL act_active_err_pulse: got %b required 0", cmd_err); end
  endtask

  task automatic test_write_read();
    logic [3:0] d [BL];
    for (int k = 0; k < BL; k++) d[k] = 4'($urandom);
    write_burst(10'd0, d, BL);
    read_burst(10'd0, 1'b1);
  endtask

  task automatic test_wrap();
    logic [3:0] d [BL];
    for (int k = 0; k < BL; k++) d[k] = 4'(k);
    write_burst(10'd5, d, BL);
    for (int k = 0; k < BL; k++) exp_q.push_back(4'((k + 3) % BL));
    read_burst(10'd0, 1'b0);
  endtask

  task automatic test_precharge_isolation();
    logic [3:0] d [BL];
    issue(CMD_PRE, '0, '0);
    for (int j = 0; j <= TRP; j++) begin
      tests += 2;
      if (row_open !== 1'b0)        begin fails++; $display("FAIL pre_row_open: E0+%0d got %b required 0", j, row_open); end
      if (cmd_ready !== (j == TRP)) begin fails++; $display("FAIL pre_ready: E0+%0d got %b required %b", j, cmd_ready, (j == TRP)); end
      if (j < TRP) tick();
    end
    activate(5'd2);
    for (int k = 0; k < BL; k++) d[k] = 4'($urandom);
    write_burst(10'd16, d, BL);
    read_burst(10'd16, 1'b1);
    precharge();
    activate(5'd1);
    tests++;
    if (open_row !== 5'd1) begin fails++; $display("FAIL reopen_row: got %0d required 1", open_row); end
    read_burst(10'd0, 1'b1);
    read_burst(10'd2, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] a [BL];
    logic [3:0] b [BL];
    precharge();
    activate(5'd3);
    for (int k = 0; k < BL; k++) begin
      a[k] = 4'(k + 8);
      b[k] = 4'(k + 1);
    end
    write_burst(10'd0, a, BL);
    write_burst(10'd0, b, 3);
    tests += 3;
    if (dqout_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_dqout_valid: got %b required 0", dqout_valid); end
    if (row_open !== 1'b0)    begin fails++; $display("FAIL rst_mid_row_open: got %b required 0", row_open); end
    if (cmd_ready !== 1'b0)   begin fails++; $display("FAIL rst_mid_ready_in_rst: got %b required 0", cmd_ready); end
    rst = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b required 1", cmd_ready); end
    tick();
    tests += 2;
    if (row_open !== 1'b0)  begin fails++; $display("FAIL rst_mid_idle: row_open=%b required 0", row_open); end
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_idle_ready: got %b required 1", cmd_ready); end
    activate(5'd3);
    for (int k = 0; k < BL; k++) exp_q.push_back(k < 3 ? b[k] : a[k]);
    read_burst(10'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_illegal_idle();
    test_activate();
    test_illegal_active();
    test_write_read();
    test_wrap();
    test_precharge_isolation();
    test_reset_mid_burst();
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
